control_unit: RTL and testbench

//  Hardwired Moore FSM sequencing the single-bus datapath: fetch (T0-T2), decode IR[31:27], execute (T3-T7).

---
 rtl/control_unit.sv | 134 +++++++++++++
 tb/tb_control_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer driving the single-bus datapath strobes
module control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        MDRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        IRin,
  output logic        CONin,
  output logic        OUTPORTin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INPORTout,
  output logic        Cout,
  output logic        Yout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic [3:0]  ALUop,
  output logic        Run
);
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_BR = 5'b10010, OP_JR = 5'b10011;
  localparam logic [4:0] OP_IN = 5'b10110, OP_OUT = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;
  state_t state, next, fin_step;
  logic [2:0] cnt;
  logic [4:0] op;
  logic alu_op, valid, mem_step, last, fin, unused_ir;
  assign op = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign alu_op = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign valid = alu_op || op inside {OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
  // Only fetch T1, ld T6 (Read) and st T7 (Write) wait on memory
  assign mem_step = state == T1 || (state == T6 && op == OP_LD) || (state == T7 && op == OP_ST);
  assign last = !mem_step || cnt == 3'(MEM_WAIT);
  assign fin_step = (op == OP_LD || op == OP_ST) ? T7 :
                    (op == OP_BR) ? T6 :
                    (op == OP_LDI || op == OP_ADDI || alu_op) ? T5 : T3;
  assign fin = last && state == fin_step;
  // State register and per-step wait counter; counter clears whenever a step completes
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= RESET;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= last ? '0 : cnt + 3'd1;
    end
  end
  // Next-state: fetch, decode at T2, execute until the opcode's final step, then T0 or HALT on Stop
  always_comb begin
    next = state;
    case (state)
      RESET: next = T0;
      T0: next = T1;
      T1: next = last ? T2 : T1;
      T2: next = op == OP_HALT ? HALT : valid ? T3 : Stop ? HALT : T0;
      T3, T4, T5, T6, T7: next = fin ? (Stop ? HALT : T0) : last ? state_t'(state + 4'd1) : state;
      default: next = state;
    endcase
  end
  // Output decode from (state, opcode); everything not named in a step stays 0
  always_comb begin
    {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin} = '0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC} = '0;
    ALUop = 4'b0000;
    Run = !(state == RESET || state == HALT);
    case (state)
      T0: {PCout, MARin} = 2'b11;
      T1: begin
        {Read, MDRin} = 2'b11;
        PCin  = last;
        IncPC = last;
      end
      T2: {MDRout, IRin} = 2'b11;
      T3: begin
        if (op inside {OP_LD, OP_LDI, OP_ST}) {Grb, BAout, Yin} = 3'b111;
        if (alu_op || op == OP_ADDI) {Grb, Rout, Yin} = 3'b111;
        if (op == OP_BR) {Gra, Rout, CONin} = 3'b111;
        if (op == OP_JR) {Gra, Rout, PCin} = 3'b111;
        if (op == OP_IN) {INPORTout, Gra, Rin} = 3'b111;
        if (op == OP_OUT) {Gra, Rout, OUTPORTin} = 3'b111;
        if (op == OP_MFHI) {HIout, Gra, Rin} = 3'b111;
        if (op == OP_MFLO) {LOout, Gra, Rin} = 3'b111;
      end
      T4: begin
        if (op inside {OP_LD, OP_LDI, OP_ST, OP_ADDI}) {Cout, Zin} = 2'b11;
        if (alu_op) begin
          {Grc, Rout, Zin} = 3'b111;
          ALUop = {2'b00, op[1:0] + 2'd1};
        end
        if (op == OP_BR) {PCout, Yin} = 2'b11;
      end
      T5: begin
        if (op == OP_LD || op == OP_ST) {ZLOout, MARin} = 2'b11;
        if (op == OP_LDI || op == OP_ADDI || alu_op) {ZLOout, Gra, Rin} = 3'b111;
        if (op == OP_BR) {Cout, Zin} = 2'b11;
      end
      T6: begin
        if (op == OP_LD) {Read, MDRin} = 2'b11;
        if (op == OP_ST) {Gra, Rout, MDRin} = 3'b111;
        if (op == OP_BR) {ZLOout, PCin} = {CON, CON};
      end
      T7: begin
        if (op == OP_LD) {MDRout, Gra, Rin} = 3'b111;
        if (op == OP_ST) Write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle strobe checks of the sequencer at MEM_WAIT=0 and MEM_WAIT=2
module tb_control_unit;
  localparam logic [28:0] PCIN = 29'd1 << 2, MDRIN = 29'd1 << 3, ZIN = 29'd1 << 4, YIN = 29'd1 << 5;
  localparam logic [28:0] MARIN = 29'd1 << 6, IRIN = 29'd1 << 7, CONIN = 29'd1 << 8, OUTPORTIN = 29'd1 << 9;
  localparam logic [28:0] HIOUT = 29'd1 << 10, ZLOOUT = 29'd1 << 13, PCOUT = 29'd1 << 14, MDROUT = 29'd1 << 15;
  localparam logic [28:0] INPORTOUT = 29'd1 << 16, COUT = 29'd1 << 17, GRA = 29'd1 << 19, GRB = 29'd1 << 20;
  localparam logic [28:0] GRC = 29'd1 << 21, RIN = 29'd1 << 22, ROUT = 29'd1 << 23, BAOUT = 29'd1 << 24;
  localparam logic [28:0] READ = 29'd1 << 25, WRITE = 29'd1 << 26, INCPC = 29'd1 << 27, RUN = 29'd1 << 28;
  logic Clock, Reset_n, Stop, CON, rst_w;
  logic [31:0] IR, ir_w;
  logic [28:0] o, w;
  logic [3:0] alu_o, alu_w;
  int checks = 0, failures = 0;
  control_unit #(.MEM_WAIT(0)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Stop(Stop), .IR(IR), .CON(CON),
    .HIin(o[0]), .LOin(o[1]), .PCin(o[2]), .MDRin(o[3]), .Zin(o[4]), .Yin(o[5]), .MARin(o[6]),
    .IRin(o[7]), .CONin(o[8]), .OUTPORTin(o[9]), .HIout(o[10]), .LOout(o[11]), .ZHIout(o[12]),
    .ZLOout(o[13]), .PCout(o[14]), .MDRout(o[15]), .INPORTout(o[16]), .Cout(o[17]), .Yout(o[18]),
    .Gra(o[19]), .Grb(o[20]), .Grc(o[21]), .Rin(o[22]), .Rout(o[23]), .BAout(o[24]), .Read(o[25]),
    .Write(o[26]), .IncPC(o[27]), .ALUop(alu_o), .Run(o[28]));
  control_unit #(.MEM_WAIT(2)) dutw (
    .Clock(Clock), .Reset_n(rst_w), .Stop(1'b0), .IR(ir_w), .CON(1'b0),
    .HIin(w[0]), .LOin(w[1]), .PCin(w[2]), .MDRin(w[3]), .Zin(w[4]), .Yin(w[5]), .MARin(w[6]),
    .IRin(w[7]), .CONin(w[8]), .OUTPORTin(w[9]), .HIout(w[10]), .LOout(w[11]), .ZHIout(w[12]),
    .ZLOout(w[13]), .PCout(w[14]), .MDRout(w[15]), .INPORTout(w[16]), .Cout(w[17]), .Yout(w[18]),
    .Gra(w[19]), .Grb(w[20]), .Grc(w[21]), .Rin(w[22]), .Rout(w[23]), .BAout(w[24]), .Read(w[25]),
    .Write(w[26]), .IncPC(w[27]), .ALUop(alu_w), .Run(w[28]));
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [28:0] exp);
    chk(tag, {3'b0, o}, {3'b0, exp});
    @(negedge Clock);
  endtask
  task automatic cycw(input string tag, input logic [28:0] exp);
    chk(tag, {3'b0, w}, {3'b0, exp});
    @(negedge Clock);
  endtask
  task automatic fetch(input string t);
    cyc({t, "_t0"}, RUN | PCOUT | MARIN);
    cyc({t, "_t1"}, RUN | READ | MDRIN | PCIN | INCPC);
    cyc({t, "_t2"}, RUN | MDROUT | IRIN);
  endtask
  task automatic do_reset();
    Reset_n = 1'b0;
    #1 chk("rst_async", {3'b0, o}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    #1 chk("rst_state", {3'b0, o}, 32'd0);
    @(negedge Clock);
  endtask
  initial begin
    int incs;
    Reset_n = 1'b1; rst_w = 1'b1; Stop = 1'b0; CON = 1'b0; IR = '0; ir_w = '0;
    #2 Reset_n = 1'b0; rst_w = 1'b0;
    @(negedge Clock);
    chk("reset_out", {3'b0, o}, 32'd0);
    chk("reset_alu", {28'd0, alu_o}, 32'd0);
    Reset_n = 1'b1;
    #1 chk("reset_hold", {3'b0, o}, 32'd0);
    @(negedge Clock);
    IR = {5'b00100, 27'd0};
    fetch("sub");
    cyc("sub_t3", RUN | GRB | ROUT | YIN);
    chk("sub_alu", {28'd0, alu_o}, 32'd1);
    cyc("sub_t4", RUN | GRC | ROUT | ZIN);
    cyc("sub_t5", RUN | ZLOOUT | GRA | RIN);
    IR = {5'b00110, 27'd0};
    fetch("or");
    cyc("or_t3", RUN | GRB | ROUT | YIN);
    chk("or_alu", {28'd0, alu_o}, 32'd3);
    cyc("or_t4", RUN | GRC | ROUT | ZIN);
    cyc("or_t5", RUN | ZLOOUT | GRA | RIN);
    IR = {5'b00011, 27'd0};
    fetch("add");
    cyc("add_t3", RUN | GRB | ROUT | YIN);
    chk("add_alu", {28'd0, alu_o}, 32'd0);
    chk("add_t4", {3'b0, o}, {3'b0, RUN | GRC | ROUT | ZIN});
    #2 do_reset();
    IR = {5'b10010, 4'd6, 4'd0, 19'd25};
    CON = 1'b1;
    fetch("br1");
    cyc("br1_t3", RUN | GRA | ROUT | CONIN);
    cyc("br1_t4", RUN | PCOUT | YIN);
    cyc("br1_t5", RUN | COUT | ZIN);
    cyc("br1_t6", RUN | ZLOOUT | PCIN);
    CON = 1'b0;
    fetch("br0");
    cyc("br0_t3", RUN | GRA | ROUT | CONIN);
    cyc("br0_t4", RUN | PCOUT | YIN);
    cyc("br0_t5", RUN | COUT | ZIN);
    cyc("br0_t6", RUN);
    IR = {5'b10011, 27'd0};
    fetch("jr");
    cyc("jr_t3", RUN | GRA | ROUT | PCIN);
    IR = {5'b10110, 27'd0};
    fetch("in");
    cyc("in_t3", RUN | INPORTOUT | GRA | RIN);
    IR = {5'b11000, 27'd0};
    fetch("mfhi");
    cyc("mfhi_t3", RUN | HIOUT | GRA | RIN);
    IR = {5'b10111, 27'd0};
    fetch("out");
    cyc("out_t3", RUN | GRA | ROUT | OUTPORTIN);
    IR = {5'b11111, 27'd0};
    fetch("bad");
    IR = {5'b00010, 27'd0};
    fetch("st");
    cyc("st_t3", RUN | GRB | BAOUT | YIN);
    Stop = 1'b1;
    cyc("st_t4", RUN | COUT | ZIN);
    Stop = 1'b0;
    cyc("st_t5", RUN | ZLOOUT | MARIN);
    Stop = 1'b1;
    cyc("st_t6", RUN | GRA | ROUT | MDRIN);
    cyc("st_t7", RUN | WRITE);
    cyc("st_halt", '0);
    Stop = 1'b0;
    cyc("st_halt2", '0);
    cyc("st_halt3", '0);
    do_reset();
    IR = {5'b11011, 27'd0};
    fetch("halt");
    cyc("halt_st", '0);
    IR = {5'b00011, 27'd0};
    cyc("halt_st2", '0);
    do_reset();
    fetch("after");
    ir_w = {5'b00000, 27'd0};
    rst_w = 1'b1;
    #1 chk("ldw_reset", {3'b0, w}, 32'd0);
    @(negedge Clock);
    incs = 0;
    cycw("ldw_t0", RUN | PCOUT | MARIN);
    for (int i = 0; i < 3; i++) begin
      incs += int'(w[27]);
      cycw("ldw_t1", (i == 2) ? (RUN | READ | MDRIN | PCIN | INCPC) : (RUN | READ | MDRIN));
    end
    cycw("ldw_t2", RUN | MDROUT | IRIN);
    cycw("ldw_t3", RUN | GRB | BAOUT | YIN);
    chk("ldw_alu", {28'd0, alu_w}, 32'd0);
    cycw("ldw_t4", RUN | COUT | ZIN);
    cycw("ldw_t5", RUN | ZLOOUT | MARIN);
    for (int i = 0; i < 3; i++) begin
      incs += int'(w[27]);
      cycw("ldw_t6", RUN | READ | MDRIN);
    end
    cycw("ldw_t7", RUN | MDROUT | GRA | RIN);
    cycw("ldw_next_t0", RUN | PCOUT | MARIN);
    chk("ldw_incpc", incs, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
